// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Two-entry in-order output buffer behind the ALU logic units. Each
//   accepted result is stored together with its opcode and a flag nibble
//   computed at capture time, and is presented downstream with a
//   valid/ready handshake. A saturating counter tracks delivered results.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset
//   in_valid    upstream presents a result
//   in_ready    stage can accept a result (registered state only)
//   in_result   result value from the producing unit
//   in_opcode   opcode that produced in_result
//   in_carry    carry-out from the producing unit
//   out_valid   head entry is presented downstream
//   out_ready   downstream consumes the head entry
//   out_result  head entry result
//   out_opcode  head entry opcode
//   out_flags   head entry flags {carry, negative, zero, parity}
//   done_count  results delivered since reset, saturating at 255
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | no entries buffered, out_valid low
// ONE   | head entry valid, tail slot free
// FULL  | head and tail valid, in_ready low

module alu_result_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_opcode,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_opcode,
    output logic [3:0]       out_flags,
    output logic [7:0]       done_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int ENTRY_W = WIDTH + 8;

    state_t               state;
    state_t               state_next;
    logic [ENTRY_W-1:0]   head_q;
    logic [ENTRY_W-1:0]   tail_q;
    logic [ENTRY_W-1:0]   new_entry;
    logic [3:0]           new_flags;
    logic                 in_fire;
    logic                 out_fire;
    logic                 load_head_new;
    logic                 load_tail_new;
    logic                 head_from_tail;

    // Flags are frozen with the entry so they always match the stored data.
    assign new_flags = {in_carry, in_result[WIDTH-1], ~|in_result, ^in_result};
    assign new_entry = {in_opcode, new_flags, in_result};

    // Handshake qualifiers come from the registered state only.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_next     = state;
        load_head_new  = 1'b0;
        load_tail_new  = 1'b0;
        head_from_tail = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next    = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    // Head leaves and the new result replaces it: no bubble.
                    state_next    = ONE;
                    load_head_new = 1'b1;
                end else if (in_fire) begin
                    state_next    = FULL;
                    load_tail_new = 1'b1;
                end else if (out_fire) begin
                    state_next    = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next     = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head_new) begin
                head_q <= new_entry;
            end else if (head_from_tail) begin
                head_q <= tail_q;
            end
            if (load_tail_new) begin
                tail_q <= new_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_count <= 8'd0;
        end else if (out_fire && (done_count != 8'hFF)) begin
            done_count <= done_count + 8'd1;
        end
    end

    assign out_result = head_q[WIDTH-1:0];
    assign out_flags  = head_q[WIDTH+3:WIDTH];
    assign out_opcode = head_q[WIDTH+7:WIDTH+4];

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage
//   Directed bench for alu_result_stage: reset values, single transfer,
//   back-pressure with a full buffer, steady streaming in ONE, flag
//   encoding, done_count saturation and reset of a full buffer.

module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_opcode;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_opcode;
    logic [3:0]  out_flags;
    logic [7:0]  done_count;

    int total_checks;
    int passed_checks;

    alu_result_stage #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_opcode  (in_opcode),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_flags  (out_flags),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] op, input logic c);
        in_valid  = v;
        in_result = r;
        in_opcode = op;
        in_carry  = c;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        tick();
        tick();

        // Reset state
        chk("rst_in_ready",   in_ready,   1);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_opcode", out_opcode, 0);
        chk("rst_out_flags",  out_flags,  0);
        chk("rst_done_count", done_count, 0);
        rst = 1'b0;

        // Single transfer, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 16'h00FF, 4'h3, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        chk("t1_out_valid",  out_valid,  1);
        chk("t1_out_result", out_result, 16'h00FF);
        chk("t1_out_opcode", out_opcode, 4'h3);
        chk("t1_out_flags",  out_flags,  4'b0000);
        chk("t1_done_before", done_count, 0);
        tick();
        chk("t1_done_count", done_count, 1);
        chk("t1_out_valid_after", out_valid, 0);
        chk("t1_in_ready", in_ready, 1);

        // Back-pressure: fill to FULL
        out_ready = 1'b0;
        drive(1'b1, 16'hFF00, 4'h1, 1'b0);
        tick();
        chk("bp_in_ready_one", in_ready, 1);
        drive(1'b1, 16'h0000, 4'h2, 1'b0);
        tick();
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_head_result", out_result, 16'hFF00);
        chk("bp_head_flags",  out_flags,  4'b0100);
        // Offered while full: must be ignored
        drive(1'b1, 16'h1234, 4'h7, 1'b1);
        tick();
        tick();
        chk("bp_hold_result", out_result, 16'hFF00);
        chk("bp_hold_opcode", out_opcode, 4'h1);
        chk("bp_hold_flags",  out_flags,  4'b0100);
        chk("bp_hold_valid",  out_valid,  1);
        chk("bp_hold_done",   done_count, 1);
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("bp_second_result", out_result, 16'h0000);
        chk("bp_second_opcode", out_opcode, 4'h2);
        chk("bp_second_flags",  out_flags,  4'b0010);
        chk("bp_done_after_first", done_count, 2);
        chk("bp_in_ready_drain", in_ready, 1);
        tick();
        chk("bp_done_after_second", done_count, 3);
        chk("bp_empty_valid", out_valid, 0);

        // Steady streaming in ONE
        out_ready = 1'b0;
        drive(1'b1, 16'h0100, 4'h4, 1'b0);
        tick();
        chk("st_head0", out_result, 16'h0100);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0101 + 16'(i), 4'h4, 1'b0);
            tick();
            chk("st_in_ready",  in_ready,  1);
            chk("st_out_valid", out_valid, 1);
            chk("st_out_result", out_result, 16'h0101 + 16'(i));
            chk("st_done", done_count, 32'(4 + i));
        end
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        tick();
        chk("st_drain_valid", out_valid, 0);
        chk("st_drain_done", done_count, 14);

        // Carry and negative flags
        out_ready = 1'b0;
        drive(1'b1, 16'h8001, 4'h5, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        chk("fl_result", out_result, 16'h8001);
        chk("fl_flags",  out_flags,  4'b1100);
        chk("fl_opcode", out_opcode, 4'h5);
        out_ready = 1'b1;
        tick();
        chk("fl_done", done_count, 15);

        // Stream 300 results; count must saturate
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'(i), 4'h6, 1'b0);
            tick();
            if (i == 99) chk("sat_mid_done", done_count, 114);
        end
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        tick();
        chk("sat_done", done_count, 255);
        chk("sat_empty", out_valid, 0);
        drive(1'b1, 16'h0001, 4'h6, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        tick();
        tick();
        chk("sat_hold", done_count, 255);

        // Reset while FULL, with a transfer offered in the reset cycle
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 4'h8, 1'b0);
        tick();
        drive(1'b1, 16'h5555, 4'h9, 1'b0);
        tick();
        chk("rf_full", in_ready, 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'h7777, 4'hA, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 4'h0, 1'b0);
        chk("rf_out_valid", out_valid, 0);
        chk("rf_in_ready",  in_ready,  1);
        chk("rf_done",      done_count, 0);
        chk("rf_result",    out_result, 0);
        chk("rf_flags",     out_flags,  0);
        tick();
        tick();
        chk("rf_still_empty", out_valid, 0);
        chk("rf_done_still",  done_count, 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
